// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB3 initiator turning a valid/ready command stream into APB transfers
//
// Clock/reset : PCLK, PRESETn (asynchronous assert, active-low)
// Command     : cmd_valid/cmd_ready handshake, cmd_write, cmd_addr (bits [1:0] ignored), cmd_wdata
// Response    : rsp_valid/rsp_ready handshake, rsp_rdata (0 for writes/errors), rsp_err, rsp_timeout
// APB3        : PSEL, PENABLE, PWRITE, PADDR, PWDATA out; PRDATA, PREADY, PSLVERR in
// Option      : define APB_INITIATOR_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
//               cycles without PREADY; otherwise ACCESS waits forever and rsp_timeout is 0.
module apb_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("apb_initiator: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  accept, done, abort, rsp_hs;

    assign accept = state_q == IDLE && cmd_ready_q && cmd_valid;
    assign done   = state_q == ACCESS && PREADY;
    assign rsp_hs = state_q == RESP && rsp_ready;

`ifdef APB_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    // cnt_q holds the number of earlier not-ready ACCESS cycles, so the abort fires at the end
    // of the TIMEOUT_CYCLES-th one; PREADY in that same cycle still completes normally.
    assign abort = state_q == ACCESS && !PREADY && cnt_q == TO_LAST;
    always_comb begin
        cnt_d         = state_q == SETUP ? 16'd0 : (state_q == ACCESS && !PREADY) ? cnt_q + 16'd1 : cnt_q;
        rsp_timeout_d = done ? 1'b0 : abort ? 1'b1 : rsp_timeout_q;
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (done || abort) ? RESP : ACCESS;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // cmd_ready also rises in IDLE right after reset release, one edge after PRESETn goes high
        cmd_ready_d = state_q == IDLE ? !accept : rsp_hs;
        psel_d      = accept ? 1'b1 : (done || abort) ? 1'b0 : psel_q;
        penable_d   = state_q == SETUP ? 1'b1 : (done || abort) ? 1'b0 : penable_q;
        pwrite_d    = accept ? cmd_write : pwrite_q;
        paddr_d     = accept ? (cmd_addr & ~ADDR_WIDTH'(3)) : paddr_q;
        pwdata_d    = accept ? cmd_wdata : pwdata_q;
        rsp_valid_d = (done || abort) ? 1'b1 : rsp_hs ? 1'b0 : rsp_valid_q;
        rsp_rdata_d = done ? ((pwrite_q || PSLVERR) ? '0 : PRDATA) : abort ? '0 : rsp_rdata_q;
        rsp_err_d   = done ? PSLVERR : abort ? 1'b1 : rsp_err_q;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: scoreboard bench for apb_initiator with a randomized APB responder and reference model
module tb_apb_initiator;
    localparam int TMO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    apb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
        int          acc0;
    } rsp_t;
    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        err;
        int          acc0;
    } plan_t;

    rsp_t  exp_q[$];
    plan_t plan_q[$];
    int    ntests = 0, nfail = 0, cyc = 0, outstanding = 0, hold_left = 0;
    bit    rdy_all = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        ntests++;
        nfail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference timing: APB3 takes setup + (waits+1) access cycles; a timed-out transfer
    // spends exactly TMO access cycles before the response is raised.
    function automatic bit timed_out(input int waits);
`ifdef APB_INITIATOR_TIMEOUT_EN
        return waits >= TMO;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input int waits);
        return timed_out(waits) ? 2 + TMO : 3 + waits;
    endfunction

    always @(posedge PCLK) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    always @(posedge PCLK) begin
        #1;
        if (rsp_valid && hold_left > 0) begin
            rsp_ready = 1'b0;
            hold_left--;
        end else rsp_ready = rdy_all || ($urandom_range(99, 0) < 70);
    end

    // APB responder: follows the per-transfer plan and checks the bus side of each transfer
    plan_t rp;
    bit    rbusy = 0;
    int    racc = 0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            rbusy = 0;
            PREADY = 1'b0;
        end else if (PSEL && !PENABLE) begin
            if (plan_q.size() == 0) flag("unplanned_setup");
            else begin
                rp = plan_q.pop_front();
                rbusy = 1;
                racc = 0;
                chk("setup_cycle", 64'(cyc - rp.acc0), 64'd1);
                chk("setup_paddr", 64'(PADDR), 64'(rp.addr & 32'hFFFF_FFFC));
                chk("setup_wr_data", 64'({PWRITE, PWDATA}), 64'({rp.w, rp.wdata}));
            end
            PREADY = 1'($urandom);
            PRDATA = $urandom;
            PSLVERR = 1'($urandom);
        end else if (PSEL && PENABLE && rbusy) begin
            if (racc == 0) chk("access_cycle", 64'(cyc - rp.acc0), 64'd2);
            chk("access_paddr", 64'(PADDR), 64'(rp.addr & 32'hFFFF_FFFC));
            chk("access_wr_data", 64'({PWRITE, PWDATA}), 64'({rp.w, rp.wdata}));
            if (racc == rp.waits) begin
                PREADY = 1'b1;
                PRDATA = rp.prdata;
                PSLVERR = rp.err;
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                PSLVERR = 1'($urandom);
            end
            racc++;
        end else begin
            if (PENABLE) flag("penable_outside_transfer");
            if (!PSEL) rbusy = 0;
            PREADY = 1'($urandom);
            PRDATA = $urandom;
            PSLVERR = 1'($urandom);
        end
    end

    // Response monitor: pops the scoreboard on each new response, then checks it stays frozen
    rsp_t        me;
    bit          held = 0;
    logic [33:0] held_v;
    always @(negedge PCLK) begin
        if (!PRESETn) held = 0;
        else if (rsp_valid) begin
            chk("cmd_ready_during_rsp", 64'(cmd_ready), 64'd0);
            if (!held) begin
                if (exp_q.size() == 0) flag("unexpected_rsp");
                else begin
                    me = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
                    chk("rsp_err_tmo", 64'({rsp_err, rsp_timeout}), 64'({me.err, me.tmo}));
                    chk("rsp_latency", 64'(cyc - me.acc0), 64'(me.lat));
                    chk("bus_idle_at_rsp", 64'({PSEL, PENABLE}), 64'd0);
                end
                held_v = {rsp_rdata, rsp_err, rsp_timeout};
            end else chk("rsp_stable", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(held_v));
            if (rsp_ready) begin
                held = 0;
                outstanding--;
            end else held = 1;
        end
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic [31:0] prd, input bit e, output int acc0);
        rsp_t  r;
        plan_t p;
        bit    ok = 0;
        acc0 = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("cmd_accept_timeout");
        else begin
            chk("single_outstanding", 64'(outstanding), 64'd0);
            outstanding++;
            acc0 = cyc;
            p = '{w: w, addr: a, wdata: d, waits: waits, prdata: prd, err: e, acc0: acc0};
            plan_q.push_back(p);
            r.tmo = timed_out(waits);
            r.err = r.tmo || e;
            r.rdata = (w || e || r.tmo) ? 32'd0 : prd;
            r.lat = exp_lat(waits);
            r.acc0 = acc0;
            exp_q.push_back(r);
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (outstanding == 0 && exp_q.size() == 0) break;
        end
        chk("drain", 64'(outstanding + exp_q.size()), 64'd0);
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, rsp_rdata}), 64'd0);
        chk({tag, "_bus"}, {PADDR, PWDATA}, 64'd0);
    endtask

    int a0, a1;
    initial begin
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA = '0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        #1 chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge PCLK);
        #1 chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        rdy_all = 1;
        issue(1, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'h0BAD_F00D, 0, a0);
        issue(0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678, 0, a0);
        issue(0, 32'h0000_0208, 32'h0, 0, 32'hCAFE_0001, 1, a0);
        wait_idle();

        issue(1, 32'h10, 32'h1, 0, 32'h0, 0, a0);
        issue(1, 32'h14, 32'h2, 0, 32'h0, 0, a1);
        chk("throughput_gap", 64'(a1 - a0), 64'd4);
        wait_idle();

        hold_left = 5;
        issue(0, 32'h20, 32'h0, 0, 32'h5555_AAAA, 0, a0);
        issue(1, 32'h24, 32'h77, 0, 32'h0, 0, a1);
        chk("hold_accept_gap", 64'(a1 - a0), 64'd9);
        wait_idle();

`ifdef APB_INITIATOR_TIMEOUT_EN
        issue(0, 32'h30, 32'h0, 1 << 20, 32'h0, 0, a0);
        wait_idle();
        issue(0, 32'h34, 32'h0, TMO - 1, 32'h8765_4321, 0, a0);
        wait_idle();
`endif

        rdy_all = 0;
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom), $urandom, $urandom, $urandom_range(5, 0), $urandom,
                  $urandom_range(3, 0) == 0, a0);
        end
        rdy_all = 1;
        wait_idle();

        issue(0, 32'h40, 32'h0, 8, 32'hAAAA_5555, 0, a0);
        for (int i = 0; i < 20 && !(PSEL && PENABLE); i++) @(negedge PCLK);
        chk("reach_access", 64'(PSEL && PENABLE), 64'd1);
        #2 PRESETn = 1'b0;
        #1 check_all_zero("reset_mid");
        exp_q.delete();
        plan_q.delete();
        outstanding = 0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        #1 chk("cmd_ready_before_edge2", 64'(cmd_ready), 64'd0);
        @(posedge PCLK);
        #1 chk("cmd_ready_after_release2", 64'(cmd_ready), 64'd1);
        issue(1, 32'h0000_0047, 32'h0123_4567, 1, 32'h0, 0, a0);
        wait_idle();
        repeat (5) @(posedge PCLK);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
